// File: rtl/park_pkg.sv
// -----------------------------------------------------------------------------
// park_pkg
// Shared constants, types and helpers for the parking-sensor event arbiter.
//   NUM_SLOTS / SLOT_W : number of occupancy sensors and width of a slot index
//   NUM_EV             : total event sources (slots first, entry last)
//   DROP_W             : width of the saturating lost-event counter
//   arb_state_t        : arbiter state (IDLE / ISSUE / GAP)
// Optional feature macro used by the top: PARK_DROP_COUNT_EN.
// -----------------------------------------------------------------------------
package park_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    localparam int NUM_EV    = NUM_SLOTS + 1;
    localparam int EV_ENTRY  = NUM_SLOTS;   // entry event lives above the slots
    localparam int DROP_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // Number of set bits in an event vector (several events may drop at once).
    function automatic logic [2:0] count_ones(input logic [NUM_EV-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_EV; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/park_event_arbiter_sensor_debounce.sv
// -----------------------------------------------------------------------------
// sensor_debounce
// Two-flop synchroniser followed by a stability counter for one raw sensor.
//   clk      : system clock
//   reset    : synchronous reset, active-high
//   i_raw    : asynchronous raw sensor level
//   o_stable : debounced level; follows the synchronised input only after it
//              has differed from the current level for DEBOUNCE_CYCLES cycles
// -----------------------------------------------------------------------------
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/park_event_arbiter.sv
// -----------------------------------------------------------------------------
// park_event_arbiter
// Turns bouncy gate/slot sensors into a clean single-cycle command stream for
// the parking FSM. Each sensor is synchronised and debounced; entry rising
// edges and slot falling edges are latched as pending events and arbitrated
// (slot0 > slot1 > slot2 > slot3 > entry) into at most one pulse, followed by
// GAP_CYCLES forced idle cycles.
//   clk          : system clock
//   reset        : synchronous reset, active-high
//   raw_entry    : raw entry-gate car-present sensor
//   raw_slot_occ : raw per-slot occupancy sensors
//   is_full      : full flag from the FSM; holds entry events pending
//   entry_signal : one-cycle entry command
//   exit_signal  : one-cycle exit command
//   exit_slot    : slot index while exit_signal=1, else 0
//   drop_count   : saturating count of lost events (PARK_DROP_COUNT_EN),
//                  tied to 0 when the macro is undefined
//   busy         : an event is pending or the arbiter is not IDLE
// -----------------------------------------------------------------------------
module park_event_arbiter
    import park_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 raw_entry,
    input  logic [NUM_SLOTS-1:0] raw_slot_occ,
    input  logic                 is_full,
    output logic                 entry_signal,
    output logic                 exit_signal,
    output logic [SLOT_W-1:0]    exit_slot,
    output logic [DROP_W-1:0]    drop_count,
    output logic                 busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [NUM_EV-1:0] w_raw;
    logic [NUM_EV-1:0] w_stable;
    logic [NUM_EV-1:0] r_stable_d;
    logic [NUM_EV-1:0] w_event;
    logic [NUM_EV-1:0] r_pend;
    logic [NUM_EV-1:0] w_elig;
    logic [NUM_EV-1:0] w_grant;
    logic [SLOT_W-1:0] w_grant_slot;
    logic              w_can_grant;
    logic              w_do_grant;

    arb_state_t        r_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_entry_sig;
    logic              r_exit_sig;
    logic [SLOT_W-1:0] r_exit_slot;

    assign w_raw = {raw_entry, raw_slot_occ};

    for (genvar g = 0; g < NUM_EV; g++) begin : g_deb
        sensor_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .reset    (reset),
            .i_raw    (w_raw[g]),
            .o_stable (w_stable[g])
        );
    end

    // Car arriving = entry rises; car leaving = slot occupancy falls.
    assign w_event[NUM_SLOTS-1:0] = r_stable_d[NUM_SLOTS-1:0] & ~w_stable[NUM_SLOTS-1:0];
    assign w_event[EV_ENTRY]      = w_stable[EV_ENTRY] & ~r_stable_d[EV_ENTRY];

    // A full lot blocks entry without discarding it.
    assign w_elig = {r_pend[EV_ENTRY] & ~is_full, r_pend[NUM_SLOTS-1:0]};

    // A grant may happen wherever the FSM would pass through IDLE: in IDLE,
    // in the last GAP cycle, or in ISSUE when no gap is configured. This keeps
    // the idle spacing between pulses at exactly GAP_CYCLES.
    assign w_can_grant = (r_state == ST_IDLE) ||
                         ((r_state == ST_ISSUE) && (GAP_CYCLES == 0)) ||
                         ((r_state == ST_GAP) && (r_gap_cnt == GAP_LAST));
    assign w_do_grant  = w_can_grant && (|w_elig);

    // NOTE: every variable driven in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_grant      = '0;
        w_grant_slot = '0;
        if (w_do_grant) begin
            for (int i = NUM_EV - 1; i >= 0; i--) begin
                // Scanning downward lets the lowest index win.
                if (w_elig[i]) begin
                    w_grant      = '0;
                    w_grant[i]   = 1'b1;
                    w_grant_slot = (i < NUM_SLOTS) ? SLOT_W'(i) : '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable_d  <= '0;
            r_pend      <= '0;
            r_state     <= ST_IDLE;
            r_gap_cnt   <= '0;
            r_entry_sig <= 1'b0;
            r_exit_sig  <= 1'b0;
            r_exit_slot <= '0;
        end else begin
            r_stable_d <= w_stable;
            // A new event in the cycle its flag is granted re-arms the flag.
            r_pend     <= (r_pend & ~w_grant) | w_event;

            r_entry_sig <= 1'b0;
            r_exit_sig  <= 1'b0;
            r_exit_slot <= '0;

            if (w_do_grant) begin
                r_state     <= ST_ISSUE;
                r_entry_sig <= w_grant[EV_ENTRY];
                r_exit_sig  <= ~w_grant[EV_ENTRY];
                r_exit_slot <= w_grant_slot;
            end else begin
                case (r_state)
                    ST_ISSUE: begin
                        r_gap_cnt <= '0;
                        r_state   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end
                    ST_GAP: begin
                        if (r_gap_cnt == GAP_LAST) r_state <= ST_IDLE;
                        else                       r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign entry_signal = r_entry_sig;
    assign exit_signal  = r_exit_sig;
    assign exit_slot    = r_exit_slot;
    assign busy         = (|r_pend) || (r_state != ST_IDLE);

`ifdef PARK_DROP_COUNT_EN
    localparam int DSUM_W = DROP_W + 1;

    logic [NUM_EV-1:0] w_drop;
    logic [DSUM_W-1:0] w_drop_sum;
    logic [DROP_W-1:0] r_drop_count;

    // Lost = event while its flag is still set and not being granted.
    assign w_drop     = w_event & r_pend & ~w_grant;
    assign w_drop_sum = {1'b0, r_drop_count} + DSUM_W'(count_ones(w_drop));

    always_ff @(posedge clk) begin
        if (reset) r_drop_count <= '0;
        else       r_drop_count <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_park_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_park_event_arbiter
// Directed bench for park_event_arbiter (DEBOUNCE_CYCLES=4, GAP_CYCLES=2).
// Expected pulses are queued as stimulus is applied; a negedge monitor pops
// and compares them whenever the DUT issues a command.
// -----------------------------------------------------------------------------
module tb_park_event_arbiter;

    typedef struct packed {
        logic       is_exit;
        logic [1:0] slot;
    } pulse_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_entry;
    logic [3:0] raw_slot_occ;
    logic       is_full;
    logic       entry_signal;
    logic       exit_signal;
    logic [1:0] exit_slot;
    logic [7:0] drop_count;
    logic       busy;

    int     tests = 0;
    int     fails = 0;
    int     cyc   = 0;
    pulse_t sb[$];
    int     pulse_cycs[$];

    park_event_arbiter #(
        .DEBOUNCE_CYCLES (4),
        .GAP_CYCLES      (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_entry    (raw_entry),
        .raw_slot_occ (raw_slot_occ),
        .is_full      (is_full),
        .entry_signal (entry_signal),
        .exit_signal  (exit_signal),
        .exit_slot    (exit_slot),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples are taken just after the falling edge, away from the active edge.
    task automatic step_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step_neg();
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n = 0;
        while (pulse_cycs.size() < target && n < budget) begin
            step_neg();
            n++;
        end
        check("pulse_timeout", 32'(pulse_cycs.size() >= target), 1);
    endtask

    // Scoreboard monitor: every issued command must match the queue head.
    always @(negedge clk) begin
        if (entry_signal || exit_signal) begin
            pulse_t e;
            pulse_cycs.push_back(cyc);
            check("pulse_exclusive", 32'(entry_signal & exit_signal), 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {exit_signal, exit_slot}, 32'hFF);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 32'(exit_signal), 32'(e.is_exit));
                check("pulse_slot", 32'(exit_slot), 32'(e.slot));
            end
        end else begin
            check("slot_zero_idle", 32'(exit_slot), 0);
        end
    end

    initial begin
        int base;
        int rel;
        int p;
        logic [7:0] exp_drop;

        // 1. Reset with entry sensor already high.
        reset        = 1'b1;
        raw_entry    = 1'b1;
        raw_slot_occ = 4'b0000;
        is_full      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_neg();
            check("reset_outputs", {entry_signal, exit_signal, exit_slot, drop_count, busy}, 0);
        end
        reset = 1'b0;
        rel   = cyc;
        sb.push_back('{is_exit: 1'b0, slot: 2'd0});
        wait_pulses(1, 20);
        check("entry_latency", pulse_cycs[0] - rel, 8);
        raw_entry = 1'b0;
        idle(12);
        check("no_pulse_on_entry_fall", pulse_cycs.size(), 1);

        // 2. Three-cycle glitch on the entry sensor.
        raw_entry = 1'b1;
        idle(3);
        raw_entry = 1'b0;
        idle(15);
        check("glitch_no_pulse", pulse_cycs.size(), 1);
        check("glitch_no_drop", drop_count, 0);

        // 3. All four slots empty in the same cycle.
        raw_slot_occ = 4'b1111;
        idle(12);
        check("no_pulse_on_occupy", pulse_cycs.size(), 1);
        base = pulse_cycs.size();
        raw_slot_occ = 4'b0000;
        for (int s = 0; s < 4; s++) sb.push_back('{is_exit: 1'b1, slot: 2'(s)});
        wait_pulses(base + 4, 40);
        for (int k = 1; k < 4; k++) begin
            check("exit_spacing", pulse_cycs[base + k] - pulse_cycs[base + k - 1], 3);
        end
        p = pulse_cycs[base + 3];
        while (cyc < p + 2) step_neg();
        check("busy_in_last_gap", busy, 1);
        step_neg();
        check("busy_after_gap", busy, 0);

        // 4. Entry blocked by is_full while slot 2 empties.
        raw_slot_occ = 4'b0100;
        idle(12);
        base = pulse_cycs.size();
        is_full      = 1'b1;
        raw_entry    = 1'b1;
        raw_slot_occ = 4'b0000;
        sb.push_back('{is_exit: 1'b1, slot: 2'd2});
        wait_pulses(base + 1, 20);
        idle(10);
        check("entry_held_while_full", pulse_cycs.size(), base + 1);
        check("busy_entry_pending", busy, 1);
        is_full = 1'b0;
        rel     = cyc;
        sb.push_back('{is_exit: 1'b0, slot: 2'd0});
        wait_pulses(base + 2, 5);
        check("entry_after_unfull", 32'((pulse_cycs[base + 1] - rel) inside {[1:2]}), 1);

        // 5. Second entry rise while the first is still blocked.
        raw_entry = 1'b0;
        idle(12);
        base    = pulse_cycs.size();
        is_full = 1'b1;
        raw_entry = 1'b1;
        idle(12);
        check("first_rise_no_drop", drop_count, 0);
        raw_entry = 1'b0;
        idle(12);
        raw_entry = 1'b1;
        idle(12);
`ifdef PARK_DROP_COUNT_EN
        exp_drop = 8'd1;
`else
        exp_drop = 8'd0;
`endif
        check("drop_count", drop_count, 32'(exp_drop));
        check("blocked_no_pulse", pulse_cycs.size(), base);
        is_full = 1'b0;
        sb.push_back('{is_exit: 1'b0, slot: 2'd0});
        wait_pulses(base + 1, 5);
        idle(10);
        check("single_entry_pulse", pulse_cycs.size(), base + 1);

        // 6. Reset during GAP with slot 1 still pending.
        raw_entry = 1'b0;
        raw_slot_occ = 4'b0011;
        idle(12);
        base = pulse_cycs.size();
        raw_slot_occ = 4'b0000;
        sb.push_back('{is_exit: 1'b1, slot: 2'd0});
        wait_pulses(base + 1, 20);
        step_neg();
        check("busy_in_gap", busy, 1);
        reset = 1'b1;
        step_neg();
        check("reset_mid_gap", {entry_signal, exit_signal, exit_slot, drop_count, busy}, 0);
        step_neg();
        reset = 1'b0;
        idle(20);
        check("no_pulse_after_reset", pulse_cycs.size(), base + 1);
        check("idle_after_reset", busy, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/park_event_arbiter.md
Name: park_event_arbiter

Overview:
- Upstream stage of the parking FSM; converts raw, bouncy sensors into the clean single-cycle command stream the FSM consumes.
- Raw sensors: one entry-gate sensor and four slot-occupancy sensors.
- Per input: synchronise, debounce, edge-detect, latch as a pending event.
- Arbitrates pending events into at most one entry_signal / exit_signal(+exit_slot) pulse, with an enforced idle gap.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles before a debounced level changes (>=1).
- GAP_CYCLES, 2, idle cycles forced after every issued pulse (>=0).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- raw_entry  in  1  entry-gate car-present sensor, asynchronous.
- raw_slot_occ  in  4  per-slot occupancy sensors, bit i = slot i, asynchronous.
- is_full  in  1  full flag from the parking FSM.
- entry_signal  out  1  one-cycle entry command to the FSM.
- exit_signal  out  1  one-cycle exit command to the FSM.
- exit_slot  out  2  slot index, valid while exit_signal=1, else 0.
- drop_count  out  8  saturating count of lost events (see Optional Feature).
- busy  out  1  high when any event is pending or state != IDLE.

Behaviour:
- Reset: all outputs 0; sync flops, debounced levels, counters and pending flags 0; state IDLE. Reset mid-operation discards in-flight pulses and pending events with no partial output.
- Synchroniser: 2-flop on each of the 5 raw inputs.
- Debounce, per input: counter clears whenever the sync output equals the stable level. Otherwise it increments; on reaching DEBOUNCE_CYCLES, stable takes the sync value and the counter clears.
- Event detection:
  - entry event = stable entry rising edge.
  - exit event i = stable slot_occ[i] falling edge.
  - Each event sets its pending flag on the next edge.
- Drops:
  - An event arriving while its own flag is already set (and not being cleared that cycle) is dropped; drop_count +1, saturating at 255.
  - An event arriving in the same cycle its flag is issued leaves the flag set; this is not a drop.
- Eligibility: exit i eligible if pending. Entry eligible if pending and is_full=0. While full, entry stays pending; it is not dropped.
- Priority: fixed, exits before entry (frees spots first): slot0 > slot1 > slot2 > slot3 > entry.
- State machine IDLE / ISSUE / GAP:
  - IDLE -> ISSUE when any event is eligible. On that edge the winner's outputs are registered and its flag cleared.
  - ISSUE lasts exactly 1 cycle, with exactly one of entry_signal / exit_signal high.
  - ISSUE -> GAP if GAP_CYCLES>0, else -> IDLE. Back-to-back pulses are allowed only when GAP_CYCLES=0.
  - GAP counts GAP_CYCLES cycles with outputs 0, then -> IDLE.
- Latency: raw change first captured at edge 1. Output pulse is registered at edge DEBOUNCE_CYCLES+4 if the arbiter is idle and the event wins arbitration.
- Glitches: a pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- Invariant: entry_signal and exit_signal are never high together.

Optional Feature:
- Macro: PARK_DROP_COUNT_EN.
- Defined: drop_count is implemented as above.
- Undefined: no counter logic; drop_count tied to 0. Event loss is otherwise identical.

Decomposition:
- Shared package park_pkg holds:
  - NUM_SLOTS=4 and SLOT_W=2.
  - State typedef (IDLE, ISSUE, GAP).
  - Drop counter width DROP_W=8.
- Sub-module sensor_debounce contains the 2-flop sync, debounce counter and stable level, with parameter DEBOUNCE_CYCLES. It is instantiated 5 times (entry + 4 slots).

Test Plan:
All with DEBOUNCE_CYCLES=4, GAP_CYCLES=2.
1. Reset held 3 cycles with raw_entry=1 -> all outputs 0 throughout. After release with raw_entry still 1 -> single entry_signal pulse exactly 8 edges after release.
2. raw_entry high 3 cycles then low (glitch) -> no entry_signal, drop_count=0.
3. raw_slot_occ 4'b1111 -> 4'b0000 in one cycle -> exit pulses in order exit_slot=0, 1, 2, 3, each separated by exactly 2 idle cycles. busy falls after the last GAP.
4. is_full=1, raw_entry rises, slot 2 empties -> exit_slot=2 pulse only, entry held pending. Drop is_full -> entry_signal pulse within 2 cycles of leaving GAP.
5. Two debounced entry rises while the first is blocked by is_full=1 -> second counted, drop_count=1 with PARK_DROP_COUNT_EN defined, 0 without. Exactly one entry pulse after is_full falls.
6. Assert reset during GAP with slot 1 pending -> all outputs 0 next cycle, no exit_slot=1 pulse afterwards, state IDLE.
